// File: rtl/mem_hs_responder.sv
// Memory-side responder for the four-phase read/write request/done handshake.
// Holds the word store and models fixed read/write access latency.
module mem_hs_responder #(
  parameter int ADDR_BITS = 6,
  parameter int DATA_BITS = 12,
  parameter int MEM_SIZE  = 64,
  parameter int RD_LAT    = 2,
  parameter int WR_LAT    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 read,
  input  logic                 write,
  output logic [DATA_BITS-1:0] dout,
  output logic                 read_done,
  output logic                 write_done,
  output logic                 busy,
  output logic                 err
);

  localparam int MAX_LAT  = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_BITS = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_BITS-1:0] RD_LOAD = CNT_BITS'(RD_LAT - 1);
  localparam logic [CNT_BITS-1:0] WR_LOAD = CNT_BITS'(WR_LAT - 1);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DONE, WR_WAIT, WR_DONE} state_t;

  state_t               state_reg;
  logic [CNT_BITS-1:0]  cnt_reg;
  logic [ADDR_BITS-1:0] addr_reg;
  logic [DATA_BITS-1:0] din_reg;
  logic [DATA_BITS-1:0] dout_reg;
  logic                 rd_done_reg;
  logic                 wr_done_reg;
  logic                 busy_reg;
  logic                 err_reg;
  logic [DATA_BITS-1:0] mem [MEM_SIZE];

  logic in_range;
  logic commit;

  assign in_range = {1'b0, addr_reg} < (ADDR_BITS + 1)'(MEM_SIZE);
  // Write lands on the same edge that raises write_done; an abort never commits.
  assign commit   = (state_reg == WR_WAIT) && write && (cnt_reg == '0) && in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= '0;
    end else if (commit) begin
      mem[addr_reg] <= din_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      din_reg     <= '0;
      dout_reg    <= '0;
      rd_done_reg <= 1'b0;
      wr_done_reg <= 1'b0;
      busy_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (read && !write) begin
            addr_reg  <= addr;
            cnt_reg   <= RD_LOAD;
            state_reg <= RD_WAIT;
            busy_reg  <= 1'b1;
          end else if (write && !read) begin
            addr_reg  <= addr;
            din_reg   <= din;
            cnt_reg   <= WR_LOAD;
            state_reg <= WR_WAIT;
            busy_reg  <= 1'b1;
          end else if (read && write) begin
            err_reg <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (!read) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (cnt_reg == '0) begin
            dout_reg    <= in_range ? mem[addr_reg] : '0;
            rd_done_reg <= 1'b1;
            err_reg     <= !in_range;
            state_reg   <= RD_DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        RD_DONE: begin
          if (!read) begin
            rd_done_reg <= 1'b0;
            state_reg   <= IDLE;
            busy_reg    <= 1'b0;
          end
        end
        WR_WAIT: begin
          if (!write) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (cnt_reg == '0) begin
            wr_done_reg <= 1'b1;
            err_reg     <= !in_range;
            state_reg   <= WR_DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        WR_DONE: begin
          if (!write) begin
            wr_done_reg <= 1'b0;
            state_reg   <= IDLE;
            busy_reg    <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign dout       = dout_reg;
  assign read_done  = rd_done_reg;
  assign write_done = wr_done_reg;
  assign busy       = busy_reg;
  assign err        = err_reg;

endmodule
